// File: rtl/bex_status_unit.sv
`default_nettype none
// ============================================================================
// Module   : bex_status_unit
// Brief    : Shadow copy of $r30 (rstatus) with overflow-code tracking, plus
//            the decode-stage bex resolver that stalls, redirects and flushes.
// Revision : 1.0 - initial release
// ============================================================================
module bex_status_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        pend_x,
    input  logic        pend_m,
    input  logic        bex_valid,
    input  logic [26:0] bex_target,
    output logic        stall,
    output logic        redirect,
    output logic [11:0] redirect_pc,
    output logic        flush,
    output logic [31:0] status,
    output logic [1:0]  exc_code,
    output logic [7:0]  exc_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT     = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    localparam logic [4:0] C_STATUS_REG = 5'd30;
    localparam logic [7:0] C_COUNT_MAX  = 8'hFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_status;
    logic [1:0]  r_exc_code;
    logic [7:0]  r_exc_count;
    logic [11:0] r_target;

    logic        w_r30_wr;
    logic        w_is_exc;
    logic        w_pending;
    logic        w_eff_nz;
    logic        w_stall;
    logic        w_redirect;
    logic        w_flush;

    // Only the low 12 target bits address the instruction memory.
    logic        w_unused_target;
    assign w_unused_target = ^bex_target[26:12];

    assign w_r30_wr  = wb_we && (wb_reg == C_STATUS_REG);
    // Overflow codes are exactly 1 (add), 2 (addi) and 3 (sub).
    assign w_is_exc  = (wb_data[31:2] == 30'd0) && (wb_data[1:0] != 2'd0);
    assign w_pending = pend_x | pend_m;
    // Bypass: a $r30 write in flight this cycle is what the bex must see.
    assign w_eff_nz  = w_r30_wr ? (wb_data != 32'd0) : (r_status != 32'd0);

    // Shadow $r30 and overflow bookkeeping; runs regardless of FSM state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_status    <= 32'd0;
            r_exc_code  <= 2'd0;
            r_exc_count <= 8'd0;
        end else if (w_r30_wr) begin
            r_status <= wb_data;
            if (w_is_exc) begin
                r_exc_code <= wb_data[1:0];
                if (r_exc_count != C_COUNT_MAX) begin
                    r_exc_count <= r_exc_count + 8'd1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the branch target on the cycle the bex is resolved as taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_target <= 12'd0;
        end else if (w_state_next == S_REDIRECT) begin
            r_target <= bex_target[11:0];
        end
    end

    // Next-state logic; bex_valid is ignored once squashing has begun.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bex_valid) begin
                    if (w_pending) begin
                        w_state_next = S_WAIT;
                    end else if (w_eff_nz) begin
                        w_state_next = S_REDIRECT;
                    end
                end
            end
            S_WAIT: begin
                if (!w_pending) begin
                    w_state_next = w_eff_nz ? S_REDIRECT : S_IDLE;
                end
            end
            S_REDIRECT: w_state_next = S_FLUSH;
            S_FLUSH:    w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Output decode; stall covers both the pending wait and the resolve cycle.
    always_comb begin
        w_stall    = 1'b0;
        w_redirect = 1'b0;
        w_flush    = 1'b0;
        case (r_state)
            S_IDLE:     w_stall = bex_valid & (w_pending | w_eff_nz);
            S_WAIT:     w_stall = w_pending | w_eff_nz;
            S_REDIRECT: begin
                w_redirect = 1'b1;
                w_flush    = 1'b1;
            end
            S_FLUSH:    w_flush = 1'b1;
            default:    w_stall = 1'b0;
        endcase
    end

    // stall depends on live inputs, so it is masked by reset directly.
    assign stall       = w_stall & reset;
    assign redirect    = w_redirect;
    assign flush       = w_flush;
    assign redirect_pc = r_target;
    assign status      = r_status;
    assign exc_code    = r_exc_code;
    assign exc_count   = r_exc_count;

endmodule
`default_nettype wire

// File: tb/tb_bex_status_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bex_status_unit
// Brief    : Scoreboard bench for bex_status_unit: directed scenarios then
//            random traffic against a behavioural model of the bex rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bex_status_unit;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        pend_x;
    logic        pend_m;
    logic        bex_valid;
    logic [26:0] bex_target;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        flush;
    logic [31:0] status;
    logic [1:0]  exc_code;
    logic [7:0]  exc_count;

    bex_status_unit dut (
        .clock       (clk),
        .reset       (rst_n),
        .wb_we       (wb_we),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .pend_x      (pend_x),
        .pend_m      (pend_m),
        .bex_valid   (bex_valid),
        .bex_target  (bex_target),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .status      (status),
        .exc_code    (exc_code),
        .exc_count   (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic        redirect;
        logic        flush;
        logic [11:0] pc;
        logic [31:0] status;
        logic [1:0]  code;
        logic [7:0]  count;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: architectural $r30 view plus "is a bex waiting" and
    // "how many squash cycles remain" (2 = redirect+flush, 1 = flush only).
    logic [31:0] m_status;
    logic [1:0]  m_code;
    int          m_count;
    logic [11:0] m_pc;
    bit          m_waiting;
    int          m_squash;

    task automatic model_clear();
        m_status  = 32'd0;
        m_code    = 2'd0;
        m_count   = 0;
        m_pc      = 12'd0;
        m_waiting = 1'b0;
        m_squash  = 0;
    endtask

    task automatic push_zero(input string tag);
        exp_t e;
        e.tag = tag; e.stall = 0; e.redirect = 0; e.flush = 0;
        e.pc = 0; e.status = 0; e.code = 0; e.count = 0;
        q.push_back(e);
    endtask

    // Expected outputs for the current cycle's inputs, then advance the model.
    task automatic model_step(input string tag);
        exp_t        e;
        bit          wr;
        logic [31:0] eff;
        int          n_squash;
        bit          n_wait;
        wr  = wb_we && (wb_reg == 5'd30);
        eff = wr ? wb_data : m_status;
        e.tag = tag; e.stall = 0; e.redirect = 0; e.flush = 0;
        e.pc = m_pc; e.status = m_status; e.code = m_code; e.count = m_count[7:0];
        n_squash = 0;
        n_wait   = 1'b0;
        if (m_squash == 2) begin
            e.redirect = 1; e.flush = 1; n_squash = 1;
        end else if (m_squash == 1) begin
            e.flush = 1;
        end else if (m_waiting || bex_valid) begin
            if (pend_x || pend_m) begin
                e.stall = 1; n_wait = 1'b1;
            end else if (eff != 0) begin
                e.stall = 1; n_squash = 2; m_pc = bex_target[11:0];
            end
        end
        q.push_back(e);
        m_squash  = n_squash;
        m_waiting = n_wait;
        if (wr) begin
            m_status = wb_data;
            if (wb_data >= 1 && wb_data <= 3) begin
                m_code = wb_data[1:0];
                if (m_count < 255) m_count = m_count + 1;
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rg, input logic [31:0] d,
                         input logic px, input logic pm, input logic bv,
                         input logic [26:0] tgt, input string tag);
        @(posedge clk);
        #1;
        wb_we = we; wb_reg = rg; wb_data = d;
        pend_x = px; pend_m = pm; bex_valid = bv; bex_target = tgt;
        model_step(tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 27'd0, tag);
    endtask

    // Assert reset mid-cycle, hold it across one more edge, release mid-cycle.
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #1;
        wb_we = 0; wb_reg = 0; wb_data = 0; pend_x = 0; pend_m = 0;
        bex_valid = 0; bex_target = 0;
        #1 rst_n = 1'b0;
        push_zero(tag);
        model_clear();
        @(posedge clk);
        #1 push_zero(tag);
        #1 rst_n = 1'b1;
    endtask

    // Direct check of all outputs late in the current cycle.
    task automatic expect_now(input string tag, input logic s, input logic r,
                              input logic f, input logic [11:0] pc,
                              input logic [31:0] st, input logic [1:0] c,
                              input logic [7:0] n);
        #5;
        n_checks++;
        if (stall !== s || redirect !== r || flush !== f || redirect_pc !== pc ||
            status !== st || exc_code !== c || exc_count !== n) begin
            n_errors++;
            $display("FAIL %s: got stall=%b redir=%b flush=%b pc=%h st=%h code=%0d cnt=%0d, want stall=%b redir=%b flush=%b pc=%h st=%h code=%0d cnt=%0d",
                     tag, stall, redirect, flush, redirect_pc, status, exc_code, exc_count,
                     s, r, f, pc, st, c, n);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (stall !== e.stall || redirect !== e.redirect || flush !== e.flush ||
                redirect_pc !== e.pc || status !== e.status || exc_code !== e.code ||
                exc_count !== e.count) begin
                n_errors++;
                $display("FAIL %s @%0t: got stall=%b redir=%b flush=%b pc=%h st=%h code=%0d cnt=%0d, want stall=%b redir=%b flush=%b pc=%h st=%h code=%0d cnt=%0d",
                         e.tag, $time, stall, redirect, flush, redirect_pc, status, exc_code,
                         exc_count, e.stall, e.redirect, e.flush, e.pc, e.status, e.code, e.count);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wb_we = 0; wb_reg = 0; wb_data = 0; pend_x = 0; pend_m = 0;
        bex_valid = 0; bex_target = 0;
        model_clear();
        @(posedge clk);
        #1 push_zero("por");
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (stall !== 0 || redirect !== 0 || flush !== 0 || status !== 0 || exc_count !== 0) begin
            n_errors++;
            $display("FAIL reset_state: got stall=%b redir=%b flush=%b st=%h cnt=%0d, want all 0",
                     stall, redirect, flush, status, exc_count);
        end

        // Overflow code write, then a taken bex.
        drive(1, 5'd30, 32'd2, 0, 0, 0, 27'd0, "wr2");
        drive(0, 5'd0, 32'd0, 0, 0, 1, 27'h0000ABC, "bex_taken");
        expect_now("bex_taken_stall", 1, 0, 0, 12'h000, 32'd2, 2'd2, 8'd1);
        idle("taken_redir");
        expect_now("taken_redir", 0, 1, 1, 12'hABC, 32'd2, 2'd2, 8'd1);
        idle("taken_flush");
        expect_now("taken_flush", 0, 0, 1, 12'hABC, 32'd2, 2'd2, 8'd1);
        idle("taken_done");
        expect_now("taken_done", 0, 0, 0, 12'hABC, 32'd2, 2'd2, 8'd1);

        // setx 0, then a not-taken bex.
        drive(1, 5'd30, 32'd0, 0, 0, 0, 27'd0, "setx0");
        drive(0, 5'd0, 32'd0, 0, 0, 1, 27'h0000555, "bex_nop");
        expect_now("bex_nop", 0, 0, 0, 12'hABC, 32'd0, 2'd2, 8'd1);
        idle("nop_after");
        expect_now("nop_after", 0, 0, 0, 12'hABC, 32'd0, 2'd2, 8'd1);

        // Pending writer, resolved through the same-cycle bypass.
        drive(0, 5'd0, 32'd0, 0, 1, 1, 27'h0123456, "wait1");
        expect_now("wait1", 1, 0, 0, 12'hABC, 32'd0, 2'd2, 8'd1);
        drive(0, 5'd0, 32'd0, 0, 1, 1, 27'h0123456, "wait2");
        expect_now("wait2", 1, 0, 0, 12'hABC, 32'd0, 2'd2, 8'd1);
        drive(1, 5'd30, 32'd3, 0, 0, 0, 27'h0123456, "wait_bypass");
        expect_now("wait_bypass", 1, 0, 0, 12'hABC, 32'd0, 2'd2, 8'd1);
        idle("bypass_redir");
        expect_now("bypass_redir", 0, 1, 1, 12'h456, 32'd3, 2'd3, 8'd2);
        idle("bypass_flush");
        expect_now("bypass_flush", 0, 0, 1, 12'h456, 32'd3, 2'd3, 8'd2);

        // Write to $r0 must not touch status.
        drive(1, 5'd0, 32'd5, 0, 0, 0, 27'd0, "wr_r0");
        idle("after_r0");
        expect_now("after_r0", 0, 0, 0, 12'h456, 32'd3, 2'd3, 8'd2);

        // Saturation of the overflow counter, then a setx value.
        for (int i = 0; i < 300; i++) drive(1, 5'd30, 32'd1, 0, 0, 0, 27'd0, "sat");
        idle("sat_done");
        expect_now("sat_done", 0, 0, 0, 12'h456, 32'd1, 2'd1, 8'd255);
        drive(1, 5'd30, 32'h1234, 0, 0, 0, 27'd0, "setx1234");
        idle("setx_done");
        expect_now("setx_done", 0, 0, 0, 12'h456, 32'h1234, 2'd1, 8'd255);

        // Reset asserted in the middle of the redirect cycle.
        drive(0, 5'd0, 32'd0, 0, 0, 1, 27'h00007FF, "bex_pre_rst");
        @(posedge clk);
        #1;
        wb_we = 0; wb_reg = 0; wb_data = 0; pend_x = 0; pend_m = 0;
        bex_valid = 0; bex_target = 0;
        n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 12'h7FF) begin
            n_errors++;
            $display("FAIL pre_rst_redir: got redir=%b pc=%h, want redir=1 pc=7ff", redirect, redirect_pc);
        end
        #1 rst_n = 1'b0;
        push_zero("rst_in_redir");
        model_clear();
        expect_now("rst_in_redir", 0, 0, 0, 12'h000, 32'd0, 2'd0, 8'd0);
        @(posedge clk);
        #1 push_zero("rst_hold");
        #1 rst_n = 1'b1;
        idle("post_rst1");
        expect_now("post_rst1", 0, 0, 0, 12'h000, 32'd0, 2'd0, 8'd0);
        idle("post_rst2");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        we;
            logic [4:0]  rg;
            logic [31:0] d;
            if ($urandom_range(0, 249) == 0) begin
                reset_pulse("rnd_rst");
            end else begin
                we = ($urandom_range(0, 1) == 1);
                rg = ($urandom_range(0, 2) != 0) ? 5'd30 : 5'($urandom_range(0, 31));
                case ($urandom_range(0, 3))
                    0:       d = 32'd0;
                    1, 2:    d = 32'($urandom_range(0, 4));
                    default: d = $urandom;
                endcase
                drive(we, rg, d, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 4) < 2), 27'($urandom), "random");
            end
        end

        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (q.size() > 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain: got %0d pending expectations, want 0", q.size());
            end
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
